// File: rtl/ccip_if_pkg.sv
// ccip_if_pkg: CCI-P channel header, request/response and port structures
package ccip_if_pkg;
    typedef logic [41:0]  t_ccip_clAddr;
    typedef logic [15:0]  t_ccip_mdata;
    typedef logic [511:0] t_ccip_clData;
    typedef logic [1:0]   t_ccip_clNum;

    typedef enum logic [1:0] {eVC_VA = 2'b00, eVC_VL0 = 2'b01, eVC_VH0 = 2'b10, eVC_VH1 = 2'b11} t_ccip_vc;
    typedef enum logic [1:0] {eCL_LEN_1 = 2'b00, eCL_LEN_2 = 2'b01, eCL_LEN_4 = 2'b11} t_ccip_clLen;
    typedef enum logic [3:0] {eREQ_RDLINE_I = 4'h0, eREQ_RDLINE_S = 4'h1} t_ccip_c0_req;
    typedef enum logic [3:0] {eREQ_WRLINE_I = 4'h0, eREQ_WRLINE_M = 4'h1, eREQ_WRPUSH_I = 4'h2, eREQ_WRFENCE = 4'h4} t_ccip_c1_req;
    typedef enum logic [3:0] {eRSP_RDLINE = 4'h0, eRSP_UMSG = 4'h4} t_ccip_c0_rsp;
    typedef enum logic [3:0] {eRSP_WRLINE = 4'h0, eRSP_WRFENCE = 4'h4} t_ccip_c1_rsp;

    typedef struct packed {
        t_ccip_vc     vc_sel;
        logic [1:0]   rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c0_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        logic [5:0]   rsvd2;
        t_ccip_vc     vc_sel;
        logic         sop;
        logic         rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic [1:0]   rsvd0;
        t_ccip_clNum  cl_num;
        t_ccip_c0_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic         format;
        logic         rsvd0;
        t_ccip_clNum  cl_num;
        t_ccip_c1_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c1_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        logic [8:0]  tid;
        logic        mmioRdValid;
        logic [63:0] data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        t_ccip_clData       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;
endpackage

// File: rtl/ccip_responder_pkg.sv
// ccip_responder_pkg: queue entry types and constants shared by the host responder
package ccip_responder_pkg;
    import ccip_if_pkg::*;

    localparam int ALM_MARGIN = 4;
    localparam int LINE_W     = 16;

    typedef struct packed {
        t_ccip_mdata       mdata;
        t_ccip_vc          vc_sel;
        logic [LINE_W-1:0] line;
        logic [7:0]        due;
    } t_rd_entry;

    typedef struct packed {
        t_ccip_mdata mdata;
        t_ccip_vc    vc_sel;
    } t_wr_entry;

    function automatic t_ccip_vc map_vc(input t_ccip_vc v);
        return (v == eVC_VA) ? eVC_VL0 : v;
    endfunction
endpackage

// File: rtl/ccip_responder_fifo.sv
// ccip_responder_fifo: request queue; a push into a full queue is taken when a pop happens alongside
module ccip_responder_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == CW'(DEPTH);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    // pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_d;
        end

    // entry storage, no reset needed
    always_ff @(posedge clk_i)
        if (do_push) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/ccip_host_responder.sv
// ccip_host_responder: CCI-P host memory model answering AFU reads/writes from a line store;
// optional read-latency jitter enabled by CCIP_RESPONDER_JITTER_EN
module ccip_host_responder
    import ccip_if_pkg::*, ccip_responder_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int MEM_LINES  = 64,
    parameter int RD_LATENCY = 4
) (
    input  logic        pClk,
    input  logic        SoftReset,
    input  t_if_ccip_Tx afu_TxPort,
    output t_if_ccip_Rx afu_RxPort,
    output logic        err_overflow,
    output logic        err_multiline
);
    localparam int LW      = $clog2(MEM_LINES);
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int ALM_LVL = FIFO_DEPTH - ALM_MARGIN;

    t_ccip_clData  store_q [MEM_LINES];
    logic [7:0]    cyc_q;
    logic [7:0]    jit;
    logic [7:0]    rd_wait;
    t_rd_entry     rd_in, rd_head;
    t_wr_entry     wr_in, wr_head;
    logic          rd_full, rd_empty, wr_full, wr_empty;
    logic [CW-1:0] rd_cnt, wr_cnt, rd_cnt_d, wr_cnt_d;
    logic          rd_push, rd_pop, wr_push, wr_pop;
    logic          c0_alm_q, c0_alm_d, c1_alm_q, c1_alm_d;
    logic          ovf_q, ovf_d, ml_q, ml_d;
    logic          unused_bits;

    assign unused_bits = ^{afu_TxPort, rd_head};

`ifdef CCIP_RESPONDER_JITTER_EN
    localparam int JIT_MAX = 127 - RD_LATENCY;
    logic [15:0] lfsr_q, lfsr_d;
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    // jitter capped so the due-time never exceeds the signed 8-bit window
    assign jit = (int'(lfsr_q[2:0]) > JIT_MAX) ? 8'(JIT_MAX) : {5'd0, lfsr_q[2:0]};
    // jitter source advances every cycle
    always_ff @(posedge pClk or posedge SoftReset)
        if (SoftReset) lfsr_q <= 16'hACE1;
        else lfsr_q <= lfsr_d;
`else
    assign jit = '0;
`endif

    ccip_responder_fifo #(.WIDTH($bits(t_rd_entry)), .DEPTH(FIFO_DEPTH)) u_rd_q (
        .clk_i(pClk), .rst_i(SoftReset), .push_i(rd_push), .din_i(rd_in), .pop_i(rd_pop),
        .dout_o(rd_head), .full_o(rd_full), .empty_o(rd_empty), .count_o(rd_cnt)
    );

    ccip_responder_fifo #(.WIDTH($bits(t_wr_entry)), .DEPTH(FIFO_DEPTH)) u_wr_q (
        .clk_i(pClk), .rst_i(SoftReset), .push_i(wr_push), .din_i(wr_in), .pop_i(wr_pop),
        .dout_o(wr_head), .full_o(wr_full), .empty_o(wr_empty), .count_o(wr_cnt)
    );

    // accept/pop decisions, queue entries and next-state of flags
    always_comb begin
        rd_in        = '0;
        rd_in.mdata  = afu_TxPort.c0.hdr.mdata;
        rd_in.vc_sel = afu_TxPort.c0.hdr.vc_sel;
        rd_in.line   = LINE_W'(afu_TxPort.c0.hdr.address[LW-1:0]);
        rd_in.due    = cyc_q + 8'(RD_LATENCY) + jit;
        wr_in        = '0;
        wr_in.mdata  = afu_TxPort.c1.hdr.mdata;
        wr_in.vc_sel = afu_TxPort.c1.hdr.vc_sel;
        rd_wait      = cyc_q - rd_head.due;
        rd_pop       = !rd_empty && !rd_wait[7];
        wr_pop       = !wr_empty;
        rd_push      = afu_TxPort.c0.valid && (!rd_full || rd_pop);
        wr_push      = afu_TxPort.c1.valid && (!wr_full || wr_pop);
        rd_cnt_d     = rd_cnt + CW'(rd_push) - CW'(rd_pop);
        wr_cnt_d     = wr_cnt + CW'(wr_push) - CW'(wr_pop);
        c0_alm_d     = rd_cnt_d >= CW'(ALM_LVL);
        c1_alm_d     = wr_cnt_d >= CW'(ALM_LVL);
        ovf_d        = ovf_q || (afu_TxPort.c0.valid && !rd_push) || (afu_TxPort.c1.valid && !wr_push);
        ml_d         = ml_q || (afu_TxPort.c0.valid && afu_TxPort.c0.hdr.cl_len != eCL_LEN_1)
                            || (afu_TxPort.c1.valid && afu_TxPort.c1.hdr.cl_len != eCL_LEN_1);
    end

    // response channels driven straight from the queue heads
    always_comb begin
        afu_RxPort                  = '0;
        afu_RxPort.c0TxAlmFull      = c0_alm_q;
        afu_RxPort.c1TxAlmFull      = c1_alm_q;
        afu_RxPort.c0.rspValid      = rd_pop;
        afu_RxPort.c0.data          = store_q[rd_head.line[LW-1:0]];
        afu_RxPort.c0.hdr.mdata     = rd_head.mdata;
        afu_RxPort.c0.hdr.vc_used   = map_vc(rd_head.vc_sel);
        afu_RxPort.c0.hdr.resp_type = eRSP_RDLINE;
        afu_RxPort.c1.rspValid      = wr_pop;
        afu_RxPort.c1.hdr.mdata     = wr_head.mdata;
        afu_RxPort.c1.hdr.vc_used   = map_vc(wr_head.vc_sel);
        afu_RxPort.c1.hdr.resp_type = eRSP_WRLINE;
    end

    assign err_overflow  = ovf_q;
    assign err_multiline = ml_q;

    // cycle counter, almost-full flags and sticky errors
    always_ff @(posedge pClk or posedge SoftReset)
        if (SoftReset) begin
            cyc_q    <= '0;
            c0_alm_q <= 1'b0;
            c1_alm_q <= 1'b0;
            ovf_q    <= 1'b0;
            ml_q     <= 1'b0;
        end else begin
            cyc_q    <= cyc_q + 8'd1;
            c0_alm_q <= c0_alm_d;
            c1_alm_q <= c1_alm_d;
            ovf_q    <= ovf_d;
            ml_q     <= ml_d;
        end

    // backing store is written in the accept cycle and survives reset
    always_ff @(posedge pClk)
        if (wr_push) store_q[afu_TxPort.c1.hdr.address[LW-1:0]] <= afu_TxPort.c1.data;
endmodule

// File: tb/tb_ccip_host_responder.sv
// tb_ccip_host_responder: directed checks of the CCI-P host responder (default and long-latency builds)
module tb_ccip_host_responder;
    import ccip_if_pkg::*;

    logic        pClk = 1'b0;
    logic        SoftReset = 1'b0;
    t_if_ccip_Tx tx_a, tx_b;
    t_if_ccip_Rx rx_a, rx_b;
    logic        ovf_a, ml_a, ovf_b, ml_b;
    logic [7:0]  tcnt;
    t_ccip_mdata q_a[$];
    t_ccip_mdata q_b[$];
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 pClk = ~pClk;

    ccip_host_responder dut_a (
        .pClk(pClk), .SoftReset(SoftReset), .afu_TxPort(tx_a), .afu_RxPort(rx_a),
        .err_overflow(ovf_a), .err_multiline(ml_a)
    );

    ccip_host_responder #(.RD_LATENCY(127)) dut_b (
        .pClk(pClk), .SoftReset(SoftReset), .afu_TxPort(tx_b), .afu_RxPort(rx_b),
        .err_overflow(ovf_b), .err_multiline(ml_b)
    );

    // bench's own view of the free-running cycle count
    always @(posedge pClk or posedge SoftReset)
        if (SoftReset) tcnt <= 8'd0;
        else tcnt <= tcnt + 8'd1;

    // log every read response, sampled mid-cycle
    always @(negedge pClk) begin
        if (rx_a.c0.rspValid) q_a.push_back(rx_a.c0.hdr.mdata);
        if (rx_b.c0.rspValid) q_b.push_back(rx_b.c0.hdr.mdata);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pClk);
        #1;
    endtask

    task automatic rd_req(input bit b, input int line, input int md, input t_ccip_clLen len, input t_ccip_vc vc);
        t_if_ccip_Tx t;
        t = '0;
        t.c0.valid        = 1'b1;
        t.c0.hdr.address  = t_ccip_clAddr'(line);
        t.c0.hdr.mdata    = t_ccip_mdata'(md);
        t.c0.hdr.cl_len   = len;
        t.c0.hdr.vc_sel   = vc;
        t.c0.hdr.req_type = eREQ_RDLINE_I;
        if (b) tx_b = t;
        else tx_a = t;
    endtask

    task automatic wr_req_a(input int line, input int md, input t_ccip_vc vc, input t_ccip_clData d);
        t_if_ccip_Tx t;
        t = '0;
        t.c1.valid        = 1'b1;
        t.c1.data         = d;
        t.c1.hdr.address  = t_ccip_clAddr'(line);
        t.c1.hdr.mdata    = t_ccip_mdata'(md);
        t.c1.hdr.cl_len   = eCL_LEN_1;
        t.c1.hdr.vc_sel   = vc;
        t.c1.hdr.sop      = 1'b1;
        t.c1.hdr.req_type = eREQ_WRLINE_I;
        tx_a = t;
    endtask

    // cycles from accept until the read response appears (1 = cycle after accept)
    task automatic wait_rsp_a(output int lat);
        lat = 1;
        while (!rx_a.c0.rspValid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    function automatic t_ccip_mdata q_at(input bit b, input int i);
        if (b) return (i < q_b.size()) ? q_b[i] : 16'hFFFF;
        return (i < q_a.size()) ? q_a[i] : 16'hFFFF;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: summary not reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int base;
        int n;
        t_ccip_clData pat;
        pat  = {64{8'hA5}};
        tx_a = '0;
        tx_b = '0;
        #2 SoftReset = 1'b1;
        repeat (3) tick();
        check("rst_c0_valid", rx_a.c0.rspValid, 0);
        check("rst_c1_valid", rx_a.c1.rspValid, 0);
        check("rst_almfull", {rx_a.c0TxAlmFull, rx_a.c1TxAlmFull, rx_b.c0TxAlmFull}, 0);
        check("rst_errs", {ovf_a, ml_a, ovf_b, ml_b}, 0);
        check("mmio_valid", {rx_a.c0.mmioRdValid, rx_a.c0.mmioWrValid}, 0);
        SoftReset = 1'b0;

        // write line 5 in the very first cycle out of reset
        wr_req_a(5, 'h11, eVC_VA, pat);
        tick();
        tx_a = '0;
        check("wr_rsp_valid", rx_a.c1.rspValid, 1);
        check("wr_rsp_mdata", rx_a.c1.hdr.mdata, 'h11);
        check("wr_rsp_type", rx_a.c1.hdr.resp_type, 0);
        check("wr_rsp_vc", rx_a.c1.hdr.vc_used, 2'b01);
        check("wr_rsp_fmt_cl", {rx_a.c1.hdr.format, rx_a.c1.hdr.cl_num}, 0);
        rd_req(0, 5, 'h22, eCL_LEN_1, eVC_VH0);
        tick();
        tx_a = '0;
        check("wr_rsp_once", rx_a.c1.rspValid, 0);
        wait_rsp_a(lat);
        check("rd_latency", lat, 4);
        check("rd_mdata", rx_a.c0.hdr.mdata, 'h22);
        check("rd_data_lo", rx_a.c0.data[63:0], 64'hA5A5_A5A5_A5A5_A5A5);
        check("rd_data_full", rx_a.c0.data == pat, 1);
        check("rd_type_cl_hit", {rx_a.c0.hdr.resp_type, rx_a.c0.hdr.cl_num, rx_a.c0.hdr.hit_miss}, 0);
        check("rd_vc", rx_a.c0.hdr.vc_used, 2'b10);
        tick();
        check("rd_rsp_once", rx_a.c0.rspValid, 0);

        // multi-line read is answered once and flagged
        check("ml_before", ml_a, 0);
        base = q_a.size();
        rd_req(0, 5, 'h33, eCL_LEN_4, eVC_VA);
        tick();
        tx_a = '0;
        check("ml_set", ml_a, 1);
        repeat (10) tick();
        check("ml_rsp_count", q_a.size() - base, 1);
        check("ml_rsp_mdata", q_at(0, base), 'h33);

        // read accepted at counter 0xFE so its due-time wraps
        n = 0;
        while (tcnt != 8'hFE && n < 300) begin
            tick();
            n++;
        end
        rd_req(0, 5, 'h44, eCL_LEN_1, eVC_VA);
        tick();
        tx_a = '0;
        wait_rsp_a(lat);
        check("wrap_latency", lat, 4);
        check("wrap_mdata", rx_a.c0.hdr.mdata, 'h44);
        check("wrap_vc", rx_a.c0.hdr.vc_used, 2'b01);
        tick();

        // 12 back-to-back reads on the long-latency build
        base = q_b.size();
        for (int i = 0; i < 12; i++) begin
            rd_req(1, i, i, eCL_LEN_1, eVC_VA);
            tick();
            if (i == 10) check("alm_after_11", rx_b.c0TxAlmFull, 0);
            if (i == 11) check("alm_after_12", rx_b.c0TxAlmFull, 1);
        end
        tx_b = '0;
        n = 0;
        while (q_b.size() - base < 12 && n < 300) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check("order_count", q_b.size() - base, 12);
        for (int i = 0; i < 12; i++) check($sformatf("order_mdata_%0d", i), q_at(1, base + i), i);
        check("alm_drained", rx_b.c0TxAlmFull, 0);
        check("no_ovf_12", ovf_b, 0);

        // 17 reads into a 16-deep queue
        base = q_b.size();
        for (int i = 0; i < 17; i++) begin
            rd_req(1, i, 100 + i, eCL_LEN_1, eVC_VA);
            tick();
            if (i == 15) check("ovf_at_16", ovf_b, 0);
            if (i == 16) check("ovf_at_17", ovf_b, 1);
        end
        tx_b = '0;
        check("alm_full_q", rx_b.c0TxAlmFull, 1);
        n = 0;
        while (q_b.size() - base < 16 && n < 300) begin
            tick();
            n++;
        end
        repeat (20) tick();
        check("ovf_rsp_count", q_b.size() - base, 16);
        check("ovf_first_mdata", q_at(1, base), 100);
        check("ovf_last_mdata", q_at(1, base + 15), 115);
        check("ovf_sticky", ovf_b, 1);

        // reset with three reads outstanding
        base = q_a.size();
        for (int i = 0; i < 3; i++) begin
            rd_req(0, 5, 'h50 + i, eCL_LEN_1, eVC_VA);
            tick();
        end
        tx_a = '0;
        SoftReset = 1'b1;
        tick();
        check("rst_mid_valid", rx_a.c0.rspValid, 0);
        check("rst_mid_ovf", ovf_b, 0);
        check("rst_mid_ml", ml_a, 0);
        check("rst_mid_alm", rx_b.c0TxAlmFull, 0);
        tick();
        SoftReset = 1'b0;
        repeat (10) tick();
        check("rst_no_rsp", q_a.size() - base, 0);
        rd_req(0, 5, 'h66, eCL_LEN_1, eVC_VA);
        tick();
        tx_a = '0;
        wait_rsp_a(lat);
        check("post_rst_latency", lat, 4);
        check("post_rst_mdata", rx_a.c0.hdr.mdata, 'h66);
        check("post_rst_data", rx_a.c0.data == pat, 1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
